// File: rtl/mult_pkg.sv
// Shared constants, FSM state type and operand-magnitude helper for the iterative multiplier.
package mult_pkg;

  localparam int unsigned MULT_W      = 32;
  localparam int unsigned PROD_W      = 64;
  localparam int unsigned MULT_CYCLES = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mult_state_e;

  // Two's-complement magnitude; -2^31 maps to 0x8000_0000, which is exact as unsigned.
  function automatic logic [MULT_W-1:0] mag(input logic [MULT_W-1:0] v);
    return v[MULT_W-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/multiplier_32bit_if.sv
// Request/result bundle between the multiply unit and its consumer.
interface multiplier_32bit_if;
  import mult_pkg::*;

  logic              mult_begin;
  logic [MULT_W-1:0] operand1;
  logic [MULT_W-1:0] operand2;
  logic [PROD_W-1:0] product;
  logic              mult_end;

  modport master (output mult_begin, operand1, operand2, input product, mult_end);
  modport slave  (input mult_begin, operand1, operand2, output product, mult_end);
endinterface

// File: rtl/multiplier_32bit.sv
// Iterative signed 32x32->64 shift-and-add multiplier: one partial product per clock,
// level-driven request, registered completion flag.
module multiplier_32bit
  import mult_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  multiplier_32bit_if.slave   bus
);

  localparam logic [5:0] LAST_ITER = 6'(MULT_CYCLES - 1);

  mult_state_e       state_q, state_d;
  logic [5:0]        count_q, count_d;
  logic [PROD_W-1:0] acc_q, acc_d;
  logic [PROD_W-1:0] mcand_q, mcand_d;
  logic [MULT_W-1:0] mplier_q, mplier_d;
  logic              sign_q, sign_d;
  logic [PROD_W-1:0] product_q, product_d;
  logic              end_q, end_d;
  logic [PROD_W-1:0] acc_sum;

  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    sign_d    = sign_q;
    product_d = product_q;
    end_d     = end_q;

    unique case (state_q)
      IDLE: begin
        if (bus.mult_begin) begin
          state_d  = BUSY;
          count_d  = '0;
          acc_d    = '0;
          mcand_d  = {{(PROD_W-MULT_W){1'b0}}, mag(bus.operand1)};
          mplier_d = mag(bus.operand2);
          sign_d   = bus.operand1[MULT_W-1] ^ bus.operand2[MULT_W-1];
        end
      end
      BUSY: begin
        if (!bus.mult_begin) begin
          state_d = IDLE;
          end_d   = 1'b0;
        end else begin
          count_d  = count_q + 6'd1;
          acc_d    = acc_sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          // Only a finished accumulation ever reaches product; aborts leave it untouched.
          if (count_q == LAST_ITER) begin
            product_d = sign_q ? (~acc_sum + 1'b1) : acc_sum;
            state_d   = DONE;
            end_d     = 1'b1;
          end
        end
      end
      DONE: begin
        if (!bus.mult_begin) begin
          state_d = IDLE;
          end_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        end_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      count_q   <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      sign_q    <= 1'b0;
      product_q <= '0;
      end_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      sign_q    <= sign_d;
      product_q <= product_d;
      end_q     <= end_d;
    end
  end

  assign bus.product  = product_q;
  assign bus.mult_end = end_q;

endmodule

// File: tb/tb_multiplier_32bit.sv
// Directed and random checks of the iterative multiplier against a plain signed-multiply model.
module tb_multiplier_32bit;

  logic clk;
  logic resetn;
  int   total;
  int   bad;

  multiplier_32bit_if bus ();

  multiplier_32bit dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    return 64'(sa * sb);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Holds the request for 40 clocks, checks rise latency, value, hold and release.
  task automatic run_case(input string tag, input logic [31:0] a, input logic [31:0] b);
    int          rise;
    logic [63:0] exp;
    exp  = model(a, b);
    rise = -1;
    @(negedge clk);
    bus.mult_begin = 1'b1;
    bus.operand1   = a;
    bus.operand2   = b;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (cyc == 5) begin
        bus.operand1 = $urandom;
        bus.operand2 = $urandom;
      end
      if (bus.mult_end === 1'b1 && rise < 0) begin
        rise = cyc;
        check({tag, " value"}, bus.product, exp);
      end
    end
    check({tag, " latency"}, 64'(rise), 64'd33);
    check({tag, " held"}, bus.product, exp);
    check({tag, " end_held"}, 64'(bus.mult_end), 64'd1);
    bus.mult_begin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({tag, " end_drop"}, 64'(bus.mult_end), 64'd0);
    check({tag, " prod_keep"}, bus.product, exp);
  endtask

  initial begin
    logic [63:0] prev;
    logic [31:0] ra;
    logic [31:0] rb;
    int          seen;
    total = 0;
    bad   = 0;
    bus.mult_begin = 1'b0;
    bus.operand1   = '0;
    bus.operand2   = '0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset product", bus.product, 64'd0);
    check("reset end", 64'(bus.mult_end), 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    run_case("1111x1111", 32'h0000_1111, 32'h0000_1111);
    check("1111x1111 const", bus.product, 64'h0000_0000_0123_4321);
    run_case("1111x2222", 32'h0000_1111, 32'h0000_2222);
    check("1111x2222 const", bus.product, 64'h0000_0000_0246_8642);
    run_case("2xneg1", 32'h0000_0002, 32'hFFFF_FFFF);
    check("2xneg1 const", bus.product, 64'hFFFF_FFFF_FFFF_FFFE);
    run_case("maxpos", 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    check("maxpos const", bus.product, 64'h3FFF_FFFF_0000_0001);
    run_case("maxneg", 32'h8000_0000, 32'h8000_0000);
    check("maxneg const", bus.product, 64'h4000_0000_0000_0000);
    run_case("114514", 32'h0011_4514, 32'h0191_9810);
    check("114514 const", bus.product, 64'd29787584999744);
    run_case("zero", 32'h0000_0000, 32'hDEAD_BEEF);
    run_case("negxpos", 32'h8000_0000, 32'h0000_0001);

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      run_case($sformatf("rand%0d", i), ra, rb);
    end

    // Abort at clock 10: no completion, product keeps previous result.
    prev = bus.product;
    seen = 0;
    @(negedge clk);
    bus.mult_begin = 1'b1;
    bus.operand1   = 32'h1234_5678;
    bus.operand2   = 32'h0000_0FFF;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (cyc == 10) bus.mult_begin = 1'b0;
      if (bus.mult_end === 1'b1) seen++;
    end
    check("abort end_seen", 64'(seen), 64'd0);
    check("abort product", bus.product, prev);

    // Restart after abort must work normally.
    run_case("after_abort", 32'hFFFF_FFF0, 32'h0000_0010);

    // Asynchronous reset mid-BUSY.
    @(negedge clk);
    bus.mult_begin = 1'b1;
    bus.operand1   = 32'h0000_00FF;
    bus.operand2   = 32'h0000_00FF;
    repeat (15) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("rst product", bus.product, 64'd0);
    check("rst end", 64'(bus.mult_end), 64'd0);
    @(negedge clk);
    bus.mult_begin = 1'b0;
    resetn = 1'b1;
    @(negedge clk);
    run_case("after_reset", 32'h0000_0003, 32'hFFFF_FFFD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
